// File: rtl/mc_ctrl_if.sv
// Bundle of the instruction fields, ALU flag and datapath control lines
// exchanged between the multi-cycle controller and its datapath.
interface mc_ctrl_if;
  logic [5:0]  op;
  logic [5:0]  func;
  logic        zero;
  logic        cnt_load;
  logic [31:0] cnt_load_value;
  logic        IRWr;
  logic        PCWr;
  logic [1:0]  npc_sel;
  logic        RegWrite;
  logic        Regdst;
  logic        link;
  logic        ALUsrcB;
  logic [2:0]  ALUop;
  logic [1:0]  Ext_sel;
  logic        MemWrite;
  logic        MemtoReg;
  logic [2:0]  state;
  logic        illegal;
  logic [31:0] instr_cnt;

  modport slave (
    input  op, func, zero, cnt_load, cnt_load_value,
    output IRWr, PCWr, npc_sel, RegWrite, Regdst, link, ALUsrcB, ALUop,
           Ext_sel, MemWrite, MemtoReg, state, illegal, instr_cnt
  );

  modport master (
    output op, func, zero, cnt_load, cnt_load_value,
    input  IRWr, PCWr, npc_sel, RegWrite, Regdst, link, ALUsrcB, ALUop,
           Ext_sel, MemWrite, MemtoReg, state, illegal, instr_cnt
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset controller: FETCH/DECODE/EXE/MEM/WB FSM with
// combinational control outputs and a retired-instruction counter.
module mc_ctrl (
  input  logic     clk,
  input  logic     reset,
  mc_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXE    = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_J, I_JAL, I_BAD
  } instr_t;

  state_t      state_reg, state_next;
  instr_t      instr;
  logic [31:0] cnt_reg;

  logic       ir_wr, pc_wr, reg_write, regdst, link, alusrcb;
  logic       mem_write, mem_to_reg, illegal;
  logic [1:0] npc_sel, ext_sel;
  logic [2:0] aluop;

  always_comb begin
    instr = I_BAD;
    case (bus.op)
      6'b000000: begin
        case (bus.func)
          6'b100001: instr = I_ADDU;
          6'b100011: instr = I_SUBU;
          6'b001000: instr = I_JR;
          default:   instr = I_BAD;
        endcase
      end
      6'b001101: instr = I_ORI;
      6'b001111: instr = I_LUI;
      6'b100011: instr = I_LW;
      6'b101011: instr = I_SW;
      6'b000100: instr = I_BEQ;
      6'b000010: instr = I_J;
      6'b000011: instr = I_JAL;
      default:   instr = I_BAD;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= FETCH;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    npc_sel    = 2'd0;
    reg_write  = 1'b0;
    regdst     = 1'b0;
    link       = 1'b0;
    alusrcb    = 1'b0;
    aluop      = 3'b000;
    ext_sel    = 2'b00;
    mem_write  = 1'b0;
    mem_to_reg = 1'b0;
    illegal    = 1'b0;

    // Datapath settings chosen in EXE stay applied until the instruction retires.
    if (state_reg == EXE || state_reg == MEM || state_reg == WB) begin
      case (instr)
        I_ADDU: begin regdst = 1'b1; aluop = 3'b000; end
        I_SUBU: begin regdst = 1'b1; aluop = 3'b001; end
        I_ORI:  begin alusrcb = 1'b1; aluop = 3'b010; ext_sel = 2'b00; end
        I_LUI:  begin alusrcb = 1'b1; aluop = 3'b011; end
        I_LW, I_SW: begin alusrcb = 1'b1; aluop = 3'b000; ext_sel = 2'b01; end
        I_BEQ:  aluop = 3'b001;
        default: ;
      endcase
    end

    case (state_reg)
      FETCH: begin
        ir_wr      = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        if (instr == I_BAD) begin
          illegal    = 1'b1;
          pc_wr      = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = EXE;
        end
      end
      EXE: begin
        state_next = FETCH;
        case (instr)
          I_ADDU, I_SUBU, I_ORI, I_LUI: state_next = WB;
          I_LW, I_SW:                   state_next = MEM;
          I_BEQ: begin
            pc_wr   = 1'b1;
            npc_sel = bus.zero ? 2'd1 : 2'd0;
          end
          I_J: begin
            pc_wr   = 1'b1;
            npc_sel = 2'd2;
          end
          I_JAL: begin
            pc_wr     = 1'b1;
            npc_sel   = 2'd2;
            reg_write = 1'b1;
            link      = 1'b1;
          end
          I_JR: begin
            pc_wr   = 1'b1;
            npc_sel = 2'd3;
          end
          default: state_next = FETCH;
        endcase
      end
      MEM: begin
        if (instr == I_SW) begin
          mem_write  = 1'b1;
          pc_wr      = 1'b1;
          state_next = FETCH;
        end else begin
          state_next = WB;
        end
      end
      WB: begin
        reg_write  = 1'b1;
        pc_wr      = 1'b1;
        mem_to_reg = (instr == I_LW);
        state_next = FETCH;
      end
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= 32'd0;
    end else if (bus.cnt_load) begin
      cnt_reg <= bus.cnt_load_value;
    end else if (pc_wr) begin
      cnt_reg <= cnt_reg + 32'd1;
    end
  end

  // Reset must silence every strobe immediately, including IRWr in FETCH.
  assign bus.IRWr      = reset & ir_wr;
  assign bus.PCWr      = reset & pc_wr;
  assign bus.npc_sel   = reset ? npc_sel : 2'd0;
  assign bus.RegWrite  = reset & reg_write;
  assign bus.Regdst    = reset & regdst;
  assign bus.link      = reset & link;
  assign bus.ALUsrcB   = reset & alusrcb;
  assign bus.ALUop     = reset ? aluop : 3'd0;
  assign bus.Ext_sel   = reset ? ext_sel : 2'd0;
  assign bus.MemWrite  = reset & mem_write;
  assign bus.MemtoReg  = reset & mem_to_reg;
  assign bus.illegal   = reset & illegal;
  assign bus.state     = reset ? state_reg : FETCH;
  assign bus.instr_cnt = cnt_reg;
endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle expected control words are queued
// for each instruction and compared cycle by cycle as the FSM walks through.
module tb_mc_ctrl;
  logic clk;
  logic reset;

  mc_ctrl_if bus ();

  mc_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] state;
    logic       ir_wr;
    logic       pc_wr;
    logic [1:0] npc_sel;
    logic       reg_write;
    logic       regdst;
    logic       link;
    logic       alusrcb;
    logic [2:0] aluop;
    logic [1:0] ext_sel;
    logic       mem_write;
    logic       mem_to_reg;
    logic       illegal;
  } ctrl_t;

  ctrl_t       sb[$];
  int          tests_run = 0;
  int          tests_failed = 0;
  logic [31:0] cnt_exp = 32'd0;

  function automatic ctrl_t sample();
    ctrl_t c;
    c.state      = bus.state;
    c.ir_wr      = bus.IRWr;
    c.pc_wr      = bus.PCWr;
    c.npc_sel    = bus.npc_sel;
    c.reg_write  = bus.RegWrite;
    c.regdst     = bus.Regdst;
    c.link       = bus.link;
    c.alusrcb    = bus.ALUsrcB;
    c.aluop      = bus.ALUop;
    c.ext_sel    = bus.Ext_sel;
    c.mem_write  = bus.MemWrite;
    c.mem_to_reg = bus.MemtoReg;
    c.illegal    = bus.illegal;
    return c;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Expected control words, one per cycle, built from the instruction table.
  task automatic push_expected(input logic [5:0] o, input logic [5:0] f, input logic z);
    ctrl_t r, b;
    bit addu, subu, jr, ori, lui, lw, sw, beq, jj, jal;
    addu = (o == 6'b000000) && (f == 6'b100001);
    subu = (o == 6'b000000) && (f == 6'b100011);
    jr   = (o == 6'b000000) && (f == 6'b001000);
    ori  = (o == 6'b001101);
    lui  = (o == 6'b001111);
    lw   = (o == 6'b100011);
    sw   = (o == 6'b101011);
    beq  = (o == 6'b000100);
    jj   = (o == 6'b000010);
    jal  = (o == 6'b000011);

    r = '0; r.state = 3'd0; r.ir_wr = 1'b1; sb.push_back(r);
    r = '0; r.state = 3'd1;
    if (!(addu || subu || jr || ori || lui || lw || sw || beq || jj || jal)) begin
      r.illegal = 1'b1; r.pc_wr = 1'b1; sb.push_back(r);
      return;
    end
    sb.push_back(r);

    b = '0;
    if (addu) begin b.regdst = 1'b1; b.aluop = 3'b000; end
    if (subu) begin b.regdst = 1'b1; b.aluop = 3'b001; end
    if (ori)  begin b.alusrcb = 1'b1; b.aluop = 3'b010; b.ext_sel = 2'b00; end
    if (lui)  begin b.alusrcb = 1'b1; b.aluop = 3'b011; end
    if (lw || sw) begin b.alusrcb = 1'b1; b.ext_sel = 2'b01; end

    r = b; r.state = 3'd2;
    if (beq) begin r.aluop = 3'b001; r.pc_wr = 1'b1; r.npc_sel = z ? 2'd1 : 2'd0; end
    if (jj)  begin r.pc_wr = 1'b1; r.npc_sel = 2'd2; end
    if (jal) begin r.pc_wr = 1'b1; r.npc_sel = 2'd2; r.reg_write = 1'b1; r.link = 1'b1; end
    if (jr)  begin r.pc_wr = 1'b1; r.npc_sel = 2'd3; end
    sb.push_back(r);
    if (beq || jj || jal || jr) return;

    if (lw || sw) begin
      r = b; r.state = 3'd3;
      if (sw) begin r.mem_write = 1'b1; r.pc_wr = 1'b1; end
      sb.push_back(r);
      if (sw) return;
    end

    r = b; r.state = 3'd4; r.reg_write = 1'b1; r.pc_wr = 1'b1; r.mem_to_reg = lw;
    sb.push_back(r);
  endtask

  // Called just after a falling edge with the FSM in FETCH.
  task automatic exec(input logic [5:0] o, input logic [5:0] f, input logic z,
                      input bit preload, input string tag);
    ctrl_t got, exp;
    int    cyc;
    bit    pl;
    pl = preload;
    bus.op = o; bus.func = f; bus.zero = z;
    push_expected(o, f, z);
    if (pl) begin
      bus.cnt_load = 1'b1;
      bus.cnt_load_value = 32'hFFFF_FFFF;
      cnt_exp = 32'hFFFF_FFFF;
    end
    cyc = 0;
    while (sb.size() > 0) begin
      #1;
      exp = sb.pop_front();
      got = sample();
      check($sformatf("%s_c%0d", tag, cyc), 32'(got), 32'(exp));
      @(negedge clk);
      if (pl) begin
        bus.cnt_load = 1'b0;
        pl = 1'b0;
        #1;
        check({tag, "_preload"}, bus.instr_cnt, 32'hFFFF_FFFF);
      end
      cyc++;
    end
    cnt_exp = cnt_exp + 32'd1;
    #1;
    check({tag, "_cnt"}, bus.instr_cnt, cnt_exp);
    $display("[TB] %s op=%b func=%b zero=%0d cycles=%0d instr_cnt=%0d",
             tag, o, f, z, cyc, bus.instr_cnt);
  endtask

  initial begin
    reset = 1'b0;
    bus.op = 6'd0; bus.func = 6'd0; bus.zero = 1'b0;
    bus.cnt_load = 1'b0; bus.cnt_load_value = 32'd0;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs", 32'(sample()), 32'd0);
    check("reset_cnt", bus.instr_cnt, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    exec(6'b001101, 6'b000000, 1'b0, 1'b0, "ori");
    exec(6'b100011, 6'b000000, 1'b0, 1'b0, "lw");
    exec(6'b101011, 6'b000000, 1'b0, 1'b0, "sw");
    exec(6'b000000, 6'b100001, 1'b0, 1'b0, "addu");
    exec(6'b000000, 6'b100011, 1'b0, 1'b0, "subu");
    exec(6'b001111, 6'b000000, 1'b0, 1'b0, "lui");
    exec(6'b000100, 6'b000000, 1'b1, 1'b0, "beq_taken");
    exec(6'b000100, 6'b000000, 1'b0, 1'b0, "beq_not");
    exec(6'b000010, 6'b000000, 1'b1, 1'b0, "j");
    exec(6'b000011, 6'b000000, 1'b0, 1'b0, "jal");
    exec(6'b000000, 6'b001000, 1'b0, 1'b0, "jr");
    exec(6'b111111, 6'b000000, 1'b0, 1'b0, "illegal_op");
    exec(6'b000000, 6'b000000, 1'b0, 1'b0, "illegal_func");

    // Abort an sw in MEM by asserting reset between clock edges.
    bus.op = 6'b101011; bus.func = 6'd0; bus.zero = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("sw_mem_state", 32'(bus.state), 32'd3);
    check("sw_mem_write", 32'(bus.MemWrite), 32'd1);
    reset = 1'b0;
    #1;
    check("abort_mem_write", 32'(bus.MemWrite), 32'd0);
    check("abort_outputs", 32'(sample()), 32'd0);
    check("abort_cnt", bus.instr_cnt, 32'd0);
    @(negedge clk);
    #1;
    check("abort_hold_cnt", bus.instr_cnt, 32'd0);
    $display("[TB] reset abort during sw MEM instr_cnt=%0d", bus.instr_cnt);
    @(negedge clk);
    reset = 1'b1;
    cnt_exp = 32'd0;

    exec(6'b001101, 6'b000000, 1'b0, 1'b1, "ori_wrap");
    exec(6'b000010, 6'b000000, 1'b0, 1'b0, "j_after_wrap");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mc_ctrl.md
MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 reset  input  1  asynchronous, active-low reset.
REQ-003 op  input  6  opcode field of the latched instruction register; stable from DECODE onward.
REQ-004 func  input  6  function field of the latched instruction register.
REQ-005 zero  input  1  ALU compare result, Y[0]; 1 = operands equal.
REQ-006 IRWr  output  1  load instruction register.
REQ-007 PCWr  output  1  load PC from npc.
REQ-008 npc_sel  output  2  next-PC source: 0 pc+4, 1 branch, 2 j-target, 3 rs.
REQ-009 RegWrite  output  1  GRF write enable.
REQ-010 Regdst  output  1  destination register: 0 rt, 1 rd.
REQ-011 link  output  1  1 = write register 31 with pc+4 (jal).
REQ-012 ALUsrcB  output  1  ALU B operand: 0 rd2, 1 extout.
REQ-013 ALUop  output  3  ALU operation: 000 add, 001 sub, 010 or, 011 lui (B<<16).
REQ-014 Ext_sel  output  2  extender mode: 00 zero-extend, 01 sign-extend.
REQ-015 MemWrite  output  1  DM write enable.
REQ-016 MemtoReg  output  1  GRF write data: 0 ALU result, 1 DM output.
REQ-017 state  output  3  current state: 0 FETCH, 1 DECODE, 2 EXE, 3 MEM, 4 WB.
REQ-018 illegal  output  1  one-cycle pulse in DECODE when the instruction is unsupported.
REQ-019 instr_cnt  output  32  count of retired instructions.

Function
REQ-020 The block SHALL be a 5-state FSM (FETCH, DECODE, EXE, MEM, WB); all outputs except instr_cnt SHALL be combinational in state, op, func and zero.
REQ-021 Supported instructions: addu (op 000000, func 100001), subu (op 000000, func 100011), jr (op 000000, func 001000), ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, j 000010, jal 000011.
REQ-022 FETCH SHALL assert IRWr and go to DECODE.
REQ-023 DECODE: any supported instruction SHALL go to EXE; an unsupported one SHALL pulse illegal, assert PCWr with npc_sel=0, and go to FETCH.
REQ-024 EXE settings:
- addu/subu: Regdst=1, ALUsrcB=0, ALUop=000/001.
- ori: Ext_sel=00, ALUsrcB=1, ALUop=010.
- lui: ALUsrcB=1, ALUop=011.
- lw/sw: Ext_sel=01, ALUsrcB=1, ALUop=000.
These settings SHALL be held through every following state of the same instruction.
REQ-025 Next state from EXE: WB for addu/subu/ori/lui; MEM for lw/sw.
REQ-026 beq SHALL complete in EXE: ALUop=001, PCWr=1, npc_sel=1 if zero else 0; then FETCH.
REQ-027 j, jal and jr SHALL complete in EXE with PCWr=1 and npc_sel=2/2/3.
REQ-028 jal SHALL also assert RegWrite and link in EXE.
REQ-029 MEM: sw SHALL assert MemWrite and PCWr (npc_sel=0) and go to FETCH; lw SHALL go to WB.
REQ-030 WB SHALL assert RegWrite and PCWr (npc_sel=0) and go to FETCH; MemtoReg=1 only for lw.
REQ-031 Cycles per instruction SHALL be: R-type ALU/ori/lui 4, lw 5, sw 4, beq/j/jal/jr 3, illegal 2.
REQ-032 RegWrite, MemWrite and PCWr SHALL each be high for at most one cycle per instruction; IRWr SHALL never be high outside FETCH.
REQ-033 instr_cnt SHALL increment by 1 on every clock edge where PCWr=1, including the illegal-instruction path, and SHALL wrap from 0xFFFFFFFF to 0.

Reset
REQ-034 While reset=0: state=FETCH, instr_cnt=0, all other outputs forced to 0 (IRWr included).
REQ-035 Reset assertion mid-instruction SHALL abort it immediately, with no further RegWrite, MemWrite or PCWr.
REQ-036 On the first rising edge after reset deasserts, the block SHALL be in FETCH with IRWr=1.

Verification
REQ-037 Release reset, op=001101 (ori) -> states 0,1,2,4,0; RegWrite=1 only in WB; ALUop=010 and ALUsrcB=1 in EXE and WB; instr_cnt=1.
REQ-038 op=100011 (lw) -> 5 cycles; MemtoReg=1 and RegWrite=1 in WB; MemWrite never 1.
REQ-039 op=000100 (beq), zero=1 then zero=0 -> npc_sel=1 then npc_sel=0 in EXE; 3 cycles each; instr_cnt=2.
REQ-040 op=000011 (jal) -> RegWrite=1, link=1, npc_sel=2 in EXE; op=000000 with func=001000 (jr) -> npc_sel=3, RegWrite=0.
REQ-041 op=111111 -> illegal pulses in DECODE; PCWr=1; back in FETCH after 2 cycles; no RegWrite or MemWrite.
REQ-042 reset=0 during MEM of sw -> MemWrite=0 at once; state=0; instr_cnt=0; instr_cnt preloaded to 0xFFFFFFFF wraps to 0 on the next retire.
